// File: rtl/timer_sched.sv
// Multi-channel periodic/one-shot tick scheduler with a round-robin event port.
// Define TIMER_OVERRUN_EN to add per-channel sticky overrun flags (o_overrun).
module timer_sched #(
  parameter int ICLK_FREQ = 50_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int NCH       = 4,
  parameter int CW        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cfg_we,
  input  logic [$clog2(NCH)-1:0] i_cfg_ch,
  input  logic [CW-1:0]          i_cfg_period,
  input  logic                   i_cfg_en,
  input  logic                   i_cfg_oneshot,
  output logic                   o_tick,
  output logic                   o_evt_valid,
  output logic [$clog2(NCH)-1:0] o_evt_ch,
  input  logic                   i_evt_ready,
`ifdef TIMER_OVERRUN_EN
  output logic [NCH-1:0]         o_pending,
  output logic [NCH-1:0]         o_overrun
`else
  output logic [NCH-1:0]         o_pending
`endif
);

  localparam int CHW = $clog2(NCH);
  localparam int PT  = ICLK_FREQ / TICK_FREQ - 1;
  localparam int PW  = (PT > 0) ? $clog2(PT + 1) : 1;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  logic [PW-1:0]  presc;
  logic [PW-1:0]  presc_nxt;
  logic [CW-1:0]  period [NCH];
  logic [CW-1:0]  count  [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] oneshot;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] acc;
  logic           evt_acc;
  logic [CHW-1:0] ptr;
  logic [CHW-1:0] ptr_inc;
  logic [CHW-1:0] grant_ch;
  logic           grant_found;
  int             idx;
  state_t         state;
  state_t         state_nxt;

  // Tick is registered one cycle ahead so it is high while presc==PT.
  assign presc_nxt = (presc == PW'(PT)) ? '0 : presc + PW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc  <= '0;
      o_tick <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      o_tick <= (presc_nxt == PW'(PT));
    end
  end

  assign evt_acc   = o_evt_valid && i_evt_ready;
  assign o_pending = pending;

  always_comb begin
    wr     = '0;
    expire = '0;
    acc    = '0;
    for (int c = 0; c < NCH; c++) begin
      wr[c]     = i_cfg_we && (i_cfg_ch == CHW'(c));
      expire[c] = o_tick && en[c] && !wr[c]
                  && (count[c] == CW'(1));
      acc[c]    = evt_acc && (o_evt_ch == CHW'(c));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < NCH; c++) begin
        period[c] <= '0;
        count[c]  <= '0;
      end
      en      <= '0;
      oneshot <= '0;
      pending <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr[c]) begin
          period[c]  <= i_cfg_period;
          count[c]   <= i_cfg_period;
          oneshot[c] <= i_cfg_oneshot;
          en[c]      <= i_cfg_en && (i_cfg_period != '0);
          pending[c] <= 1'b0;
        end else begin
          if (o_tick && en[c]) begin
            if (count[c] == CW'(1)) begin
              count[c] <= period[c];
              if (oneshot[c])
                en[c] <= 1'b0;
            end else begin
              count[c] <= count[c] - CW'(1);
            end
          end
          // Re-expiry beats a same-cycle accept.
          if (expire[c])
            pending[c] <= 1'b1;
          else if (acc[c])
            pending[c] <= 1'b0;
        end
      end
    end
  end

`ifdef TIMER_OVERRUN_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overrun <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr[c])
          o_overrun[c] <= 1'b0;
        else if (expire[c] && pending[c] && !acc[c])
          o_overrun[c] <= 1'b1;
      end
    end
  end
`endif

  // First pending channel at or after the pointer, wrapping at NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH)
        idx = idx - NCH;
      if (!grant_found && pending[idx[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = idx[CHW-1:0];
      end
    end
  end

  assign ptr_inc = (o_evt_ch == CHW'(NCH - 1)) ? '0
                                              : o_evt_ch + CHW'(1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      o_evt_ch <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_found)
        o_evt_ch <= grant_ch;
      if (evt_acc)
        ptr <= ptr_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (grant_found) state_nxt = S_PRESENT;
      S_PRESENT: if (i_evt_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_evt_valid = (state == S_PRESENT);
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: tick cadence, periodic/one-shot channels,
// round-robin grants, coalescing/overrun and asynchronous reset.
module tb_timer_sched;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic       cfg_en = 1'b0;
  logic       cfg_os = 1'b0;
  logic       evt_ready = 1'b0;
  logic       o_tick;
  logic       o_evt_valid;
  logic [1:0] o_evt_ch;
  logic [3:0] o_pending;
`ifdef TIMER_OVERRUN_EN
  logic [3:0] o_overrun;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sb_exp;
  int exp_q[$];

  timer_sched #(
    .ICLK_FREQ(8),
    .TICK_FREQ(2),
    .NCH(4),
    .CW(8)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_cfg_we(cfg_we),
    .i_cfg_ch(cfg_ch),
    .i_cfg_period(cfg_period),
    .i_cfg_en(cfg_en),
    .i_cfg_oneshot(cfg_os),
    .o_tick(o_tick),
    .o_evt_valid(o_evt_valid),
    .o_evt_ch(o_evt_ch),
    .i_evt_ready(evt_ready),
`ifdef TIMER_OVERRUN_EN
    .o_pending(o_pending),
    .o_overrun(o_overrun)
`else
    .o_pending(o_pending)
`endif
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted event must match the queue head.
  always @(negedge i_clk) begin
    if (!i_reset && o_evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_ch", int'(o_evt_ch), -1);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_ch", int'(o_evt_ch), sb_exp);
      end
    end
  end

  task automatic cfg_write(input int ch, input int per,
                           input int en, input int os);
    @(posedge i_clk);
    #1;
    cfg_we = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = 8'(per);
    cfg_en = 1'(en);
    cfg_os = 1'(os);
    @(posedge i_clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_pend(input int ch, input logic lvl,
                           input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_pending[ch] !== lvl && n < budget);
    if (o_pending[ch] !== lvl)
      chk(name, int'(o_pending[ch]), int'(lvl));
  endtask

  initial begin
    int ticks;
    int t_prev;
    int n;
    logic seen;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int t_prev;
    int n;
    logic seen;

    // Reset state.
    @(negedge i_clk);
    chk("rst_tick", int'(o_tick), 0);
    chk("rst_valid", int'(o_evt_valid), 0);
    chk("rst_pending", int'(o_pending), 0);
    chk("rst_ch", int'(o_evt_ch), 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // Tick in the 4th cycle after release, then every 4 cycles.
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      chk($sformatf("tick_k%0d", k), int'(o_tick), (k % 4 == 3) ? 1 : 0);
    end

    // Ch1 periodic, period 3 ticks, ready held high.
    evt_ready = 1'b1;
    cfg_write(1, 3, 1, 0);
    ticks = 0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (!o_pending[1] && o_tick)
        ticks++;
    end while (!o_pending[1] && n < 40);
    chk("ch1_first_ticks", ticks, 3);
    t_prev = cyc;
    exp_q.push_back(1);
    @(negedge i_clk);
    chk("ch1_valid0", int'(o_evt_valid), 1);
    chk("ch1_ch0", int'(o_evt_ch), 1);
    for (int e = 1; e < 3; e++) begin
      wait_pend(1, 1'b0, 10, "ch1_clear_timeout");
      wait_pend(1, 1'b1, 30, "ch1_rise_timeout");
      chk($sformatf("ch1_period_%0d", e), cyc - t_prev, 12);
      t_prev = cyc;
      exp_q.push_back(1);
      @(negedge i_clk);
      chk($sformatf("ch1_valid%0d", e), int'(o_evt_valid), 1);
    end

    // Period 0 disables the channel.
    cfg_write(1, 0, 1, 0);
    seen = 1'b0;
    repeat (24) begin
      @(negedge i_clk);
      if (o_pending != 4'h0 || o_evt_valid)
        seen = 1'b1;
    end
    chk("ch1_disabled_quiet", int'(seen), 0);

    // Ch0 one-shot, period 2.
    cfg_write(0, 2, 1, 1);
    wait_pend(0, 1'b1, 40, "ch0_rise_timeout");
    exp_q.push_back(0);
    @(negedge i_clk);
    chk("ch0_valid", int'(o_evt_valid), 1);
    chk("ch0_ch", int'(o_evt_ch), 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_pending != 4'h0)
        seen = 1'b1;
    end
    chk("ch0_oneshot_quiet", int'(seen), 0);

    // Fresh reset so the pointer is 0; all four one-shots pend.
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    evt_ready = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    for (int c = 0; c < 4; c++)
      cfg_write(c, 1, 1, 1);
    repeat (12) @(negedge i_clk);
    chk("all_pending", int'(o_pending), 15);
    for (int h = 0; h < 3; h++) begin
      @(negedge i_clk);
      chk($sformatf("hold_valid%0d", h), int'(o_evt_valid), 1);
      chk($sformatf("hold_ch%0d", h), int'(o_evt_ch), 0);
    end
    for (int c = 0; c < 4; c++)
      exp_q.push_back(c);
    @(posedge i_clk);
    #1;
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk($sformatf("rr_valid%0d", i), int'(o_evt_valid),
          (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0)
        chk($sformatf("rr_ch%0d", i), int'(o_evt_ch), i / 2);
    end
    chk("rr_drained", int'(o_pending), 0);

    // Ch2 period 1 with ready low for three ticks: one coalesced pending.
    @(posedge i_clk);
    #1;
    evt_ready = 1'b0;
    cfg_write(2, 1, 1, 0);
    ticks = 0;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
      if (o_tick)
        ticks++;
    end while (ticks < 3 && n < 40);
    chk("ch2_ticks_seen", ticks, 3);
    repeat (2) @(negedge i_clk);
    chk("ch2_pending", int'(o_pending), 4);
    chk("ch2_valid", int'(o_evt_valid), 1);
    chk("ch2_ch", int'(o_evt_ch), 2);
`ifdef TIMER_OVERRUN_EN
    chk("ch2_overrun_set", int'(o_overrun), 4);
`endif
    // Rewrite ch2 while presented: still delivered once.
    exp_q.push_back(2);
    @(posedge i_clk);
    #1;
    cfg_we = 1'b1;
    cfg_ch = 2'd2;
    cfg_period = 8'd0;
    cfg_en = 1'b1;
    cfg_os = 1'b0;
    @(posedge i_clk);
    #1;
    cfg_we = 1'b0;
    evt_ready = 1'b1;
    @(negedge i_clk);
    chk("ch2_rw_pending", int'(o_pending), 0);
    chk("ch2_rw_valid", int'(o_evt_valid), 1);
    chk("ch2_rw_ch", int'(o_evt_ch), 2);
`ifdef TIMER_OVERRUN_EN
    chk("ch2_overrun_clr", int'(o_overrun), 0);
`endif
    seen = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_pending != 4'h0 || o_evt_valid)
        seen = 1'b1;
    end
    chk("ch2_p0_quiet", int'(seen), 0);

    // Asynchronous reset while an event is presented.
    evt_ready = 1'b0;
    cfg_write(1, 1, 1, 0);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_evt_valid && n < 20);
    chk("ar_valid_before", int'(o_evt_valid), 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("ar_valid_async", int'(o_evt_valid), 0);
    chk("ar_pending_async", int'(o_pending), 0);
    chk("ar_ch_async", int'(o_evt_ch), 0);
    chk("ar_tick_async", int'(o_tick), 0);
    @(negedge i_clk);
    chk("ar_held_valid", int'(o_evt_valid), 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_pending != 4'h0 || o_evt_valid)
        seen = 1'b1;
    end
    chk("ar_cfg_cleared", int'(seen), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
